// File: rtl/usb_pkt_tx.sv
// USB low-speed packet transmitter: PID, optional payload with CRC16, then an
// idle gap before the next packet may start.
module usb_pkt_tx #(
    parameter int GAP_CLKS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic [3:0] len,
    output logic [2:0] buf_addr,
    input  logic [7:0] buf_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(GAP_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE, PID, DATA, CRC_LO, CRC_HI, GAP
    } state_t;

    state_t        state, state_d;
    logic [7:0]    tx_data_d;
    logic          tx_valid_d;
    logic [2:0]    buf_addr_d;
    logic          err_d;
    logic [15:0]   crc, crc_d, crc_nx;
    logic [CW-1:0] gap_cnt, gap_d;
    logic [3:0]    len_r, len_d;
    logic [3:0]    idx, idx_d;
    logic          data_pkt, data_pkt_d;
    logic          consume;
    logic          pid_data, pid_hs, pid_ok;

    // Reflected CRC16 (0x8005 -> 0xA001), one byte LSB-first.
    function automatic logic [15:0] crc16_byte(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign consume  = tx_valid & tx_ready;
    assign crc_nx   = crc16_byte(crc, tx_data);
    assign pid_data = (pid == 4'b0011) || (pid == 4'b1011);
    assign pid_hs   = (pid == 4'b0010) || (pid == 4'b1010)
                   || (pid == 4'b1110);
    assign pid_ok   = (pid_data && len <= 4'd8) || pid_hs;

    // Done occupies the last GAP cycle, so a coincident start sees a busy FSM.
    assign done = (state == GAP) && (gap_cnt == CW'(GAP_CLKS));
    assign busy = (state != IDLE) && !done;

    always_comb begin
        state_d    = state;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        buf_addr_d = buf_addr;
        err_d      = 1'b0;
        crc_d      = crc;
        gap_d      = gap_cnt;
        len_d      = len_r;
        idx_d      = idx;
        data_pkt_d = data_pkt;
        unique case (state)
            IDLE: begin
                if (start && pid_ok) begin
                    tx_data_d  = {~pid, pid};
                    tx_valid_d = 1'b1;
                    buf_addr_d = 3'd0;
                    crc_d      = 16'hFFFF;
                    len_d      = len;
                    idx_d      = 4'd0;
                    data_pkt_d = pid_data;
                    gap_d      = '0;
                    state_d    = PID;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            PID: begin
                if (consume) begin
                    if (!data_pkt) begin
                        tx_valid_d = 1'b0;
                        gap_d      = '0;
                        state_d    = GAP;
                    end else if (len_r != 4'd0) begin
                        tx_data_d  = buf_data;
                        buf_addr_d = buf_addr + 3'd1;
                        idx_d      = 4'd0;
                        state_d    = DATA;
                    end else begin
                        tx_data_d = ~crc[7:0];
                        state_d   = CRC_LO;
                    end
                end
            end
            DATA: begin
                if (consume) begin
                    crc_d = crc_nx;
                    if (idx == len_r - 4'd1) begin
                        tx_data_d = ~crc_nx[7:0];
                        state_d   = CRC_LO;
                    end else begin
                        tx_data_d  = buf_data;
                        buf_addr_d = buf_addr + 3'd1;
                        idx_d      = idx + 4'd1;
                    end
                end
            end
            CRC_LO: begin
                if (consume) begin
                    tx_data_d = ~crc[15:8];
                    state_d   = CRC_HI;
                end
            end
            CRC_HI: begin
                if (consume) begin
                    tx_valid_d = 1'b0;
                    gap_d      = '0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == CW'(GAP_CLKS)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            buf_addr <= 3'd0;
            err      <= 1'b0;
            crc      <= 16'hFFFF;
            gap_cnt  <= '0;
            len_r    <= 4'd0;
            idx      <= 4'd0;
            data_pkt <= 1'b0;
        end else begin
            state    <= state_d;
            tx_data  <= tx_data_d;
            tx_valid <= tx_valid_d;
            buf_addr <= buf_addr_d;
            err      <= err_d;
            crc      <= crc_d;
            gap_cnt  <= gap_d;
            len_r    <= len_d;
            idx      <= idx_d;
            data_pkt <= data_pkt_d;
        end
    end

endmodule

// File: doc/usb_pkt_tx.md
USB_PKT_TX -- requirements
Module: usb_pkt_tx

Interface
REQ-001 SHALL have parameter: GAP_CLKS, default 64, clocks held busy after the last byte is accepted (EOP plus inter-packet idle at low speed, 16 clk/bit).
REQ-002 SHALL have port: clk  input  1  system clock, 24 MHz; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  single-cycle packet request, sampled only in IDLE.
REQ-005 SHALL have port: pid  input  4  packet ID, sampled with start.
REQ-006 SHALL have port: len  input  4  payload byte count 0..8, sampled with start; DATA PIDs only.
REQ-007 SHALL have port: buf_addr  output  3  payload buffer read address, registered.
REQ-008 SHALL have port: buf_data  input  8  payload byte; valid one cycle after buf_addr changes; buffer stable while busy.
REQ-009 SHALL have port: tx_data  output  8  byte to the USB transmitter, registered.
REQ-010 SHALL have port: tx_valid  output  1  packet in progress; transmitter ends the packet (EOP) when it falls.
REQ-011 SHALL have port: tx_ready  input  1  transmitter consumes tx_data in any cycle with tx_ready=1 and tx_valid=1.
REQ-012 SHALL have port: busy  output  1  high from the cycle after an accepted start through the end of GAP.
REQ-013 SHALL have port: done  output  1  one-cycle pulse on GAP completion.
REQ-014 SHALL have port: err  output  1  one-cycle pulse on a rejected start.

Function
REQ-015 SHALL implement FSM states IDLE, PID, DATA, CRC_LO, CRC_HI, GAP.
REQ-016 SHALL accept start in IDLE only for pid in {0011 DATA0, 1011 DATA1} with len<=8, or {0010 ACK, 1010 NAK, 1110 STALL}; start outside IDLE SHALL be ignored without err.
REQ-017 SHALL, for any other pid or for a DATA pid with len>8, pulse err on the following cycle, remain in IDLE, and leave tx_valid at 0.
REQ-018 SHALL, on an accepted start, load tx_data={~pid,pid}, set tx_valid=1, set buf_addr=0, and enter PID at the same edge.
REQ-019 SHALL advance only on a consume cycle (tx_valid & tx_ready); tx_data SHALL hold its value between consume cycles.
REQ-020 SHALL, on consume of a handshake PID byte, clear tx_valid at that edge and enter GAP.
REQ-021 SHALL, on consume of a DATA PID byte with len>0, load tx_data=buf_data (byte 0), increment buf_addr, and enter DATA; with len=0, go directly to CRC_LO.
REQ-022 SHALL, in DATA, on consume of byte i, fold byte i into the CRC and load byte i+1 from buf_data, incrementing buf_addr; after the last byte (i=len-1), load the CRC low byte and enter CRC_LO.
REQ-023 SHALL compute USB CRC16: polynomial x^16+x^15+x^2+1, init 16'hFFFF, data LSB-first, one byte per consume cycle; the transmitted value SHALL be the ones-complement, low byte first.
REQ-024 SHALL, in CRC_LO, on consume, load the CRC high byte and enter CRC_HI; in CRC_HI, on consume, clear tx_valid and enter GAP.
REQ-025 SHALL count GAP_CLKS cycles in GAP, then pulse done for one cycle and return to IDLE, with busy falling in the same cycle that done pulses.
REQ-026 SHALL, when start arrives in the same cycle as done, ignore that start (FSM is not in IDLE).
REQ-027 SHALL keep tx_valid high continuously from the PID byte through the final byte, with no deassertion inside a packet.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, force IDLE, tx_valid=0, tx_data=0, buf_addr=0, busy=0, done=0, err=0, CRC=16'hFFFF, GAP counter=0.
REQ-029 SHALL, on reset mid-packet, drop tx_valid at that edge so that the transmitter terminates the packet, with no done pulse.

Verification
REQ-030 SHALL pass: start, pid=0010 -> tx_data=8'hD2 consumed once; tx_valid falls at the same edge; done pulses exactly GAP_CLKS cycles later.
REQ-031 SHALL pass: start, pid=0011, len=0 -> byte sequence C3,00,00, then tx_valid=0.
REQ-032 SHALL pass: start, pid=1011, len=8, buffer 01..08 -> sequence 4B,01..08,CRC_LO,CRC_HI; the CRC matches the bench reference model, and the receiver loopback reports no error.
REQ-033 SHALL pass: start, pid=0001 or pid=0011 with len=9 -> err pulse; tx_valid stays 0; busy stays 0.
REQ-034 SHALL pass: second start during DATA, and start coincident with done -> both ignored; the first packet completes unchanged.
REQ-035 SHALL pass: reset asserted after the 3rd payload byte of a len=8 packet -> tx_valid=0 next edge, all outputs at reset values, and a subsequent ACK request works normally.
